button_command_scheduler: RTL and testbench

Sequences debounced button tick pulses into configuration commands for the image processing pipeline. It latches ticks from four front-panel buttons, grants them round-robin, computes the new filter mode and zoom level, and issues one command at a time over a valid/ready handshake. After each accepted command it waits for the pipeline's completion pulse, with a timeout. It sits between the per-button debounce edge detectors and the pipeline's configuration port.

---
 rtl/button_command_scheduler.sv | 130 +++++++++++++
 tb/tb_button_command_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_command_scheduler.sv
// Turns debounced front-panel button ticks into pipeline configuration commands:
// round-robin grant, mode/zoom arithmetic, valid/ready issue, completion wait with timeout.
module button_command_scheduler #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int ZOOM_MAX  = 3,
    parameter int ZOOM_W    = 2,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_next,
    input  logic              tick_prev,
    input  logic              tick_zin,
    input  logic              tick_zout,
    input  logic              cmd_ready,
    input  logic              proc_done,
    input  logic              err_clr,
    output logic              cmd_valid,
    output logic [1:0]        cmd_code,
    output logic [MODE_W-1:0] cmd_mode,
    output logic [ZOOM_W-1:0] cmd_zoom,
    output logic [MODE_W-1:0] mode,
    output logic [ZOOM_W-1:0] zoom,
    output logic              busy,
    output logic              drop_err,
    output logic              timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state;
    logic [3:0]        pending, ticks, clr;
    logic [1:0]        rr_ptr, grant, idx;
    logic              found, take, noop, drop_now, to_now;
    logic [TW-1:0]     timer;
    logic [MODE_W-1:0] mode_nx;
    logic [ZOOM_W-1:0] zoom_nx;

    assign ticks = {tick_zout, tick_zin, tick_prev, tick_next};
    assign busy  = (state != IDLE);

    // First pending bit at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Untouched field carries the committed value; saturated zoom is a no-op.
    always_comb begin
        mode_nx = mode;
        zoom_nx = zoom;
        noop    = 1'b0;
        case (grant)
            2'd0: mode_nx = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
            2'd1: mode_nx = (mode == '0) ? MODE_W'(NUM_MODES - 1) : mode - 1'b1;
            2'd2: if (zoom == ZOOM_W'(ZOOM_MAX)) noop = 1'b1; else zoom_nx = zoom + 1'b1;
            default: if (zoom == '0) noop = 1'b1; else zoom_nx = zoom - 1'b1;
        endcase
    end

    assign take     = (state == IDLE) && found;
    assign clr      = take ? (4'b0001 << grant) : 4'b0000;
    assign drop_now = |(ticks & pending & ~clr);
    assign to_now   = (state == WAIT_DONE) && !proc_done && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            cmd_mode    <= '0;
            cmd_zoom    <= '0;
            mode        <= '0;
            zoom        <= '0;
            drop_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // A new tick beats a same-cycle grant clear of its bit.
            pending <= (pending & ~clr) | ticks;

            if (drop_now)     drop_err <= 1'b1;
            else if (err_clr) drop_err <= 1'b0;

            if (to_now)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        rr_ptr <= grant + 2'd1;
                        if (!noop) begin
                            cmd_code  <= grant;
                            cmd_mode  <= mode_nx;
                            cmd_zoom  <= zoom_nx;
                            cmd_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        mode      <= cmd_mode;
                        zoom      <= cmd_zoom;
                        cmd_valid <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (proc_done || to_now) state <= IDLE;
                    else                     timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_command_scheduler.sv
// Directed bench for button_command_scheduler; TIMEOUT shortened to 16 cycles.
module tb_button_command_scheduler;
    logic       clk = 1'b0;
    logic       rst, tick_next, tick_prev, tick_zin, tick_zout;
    logic       cmd_ready, proc_done, err_clr;
    logic       cmd_valid, busy, drop_err, timeout_err;
    logic [1:0] cmd_code, cmd_mode, cmd_zoom, mode, zoom;

    int vectors    = 0;
    int miscompares = 0;

    button_command_scheduler #(
        .NUM_MODES(4), .MODE_W(2), .ZOOM_MAX(3), .ZOOM_W(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .tick_next(tick_next), .tick_prev(tick_prev),
        .tick_zin(tick_zin), .tick_zout(tick_zout),
        .cmd_ready(cmd_ready), .proc_done(proc_done), .err_clr(err_clr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_mode(cmd_mode),
        .cmd_zoom(cmd_zoom), .mode(mode), .zoom(zoom), .busy(busy),
        .drop_err(drop_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {tick_next, tick_prev, tick_zin, tick_zout} = '0;
        {cmd_ready, proc_done, err_clr} = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse(input int b);
        {tick_zout, tick_zin, tick_prev, tick_next} = 4'(1) << b;
        step();
        {tick_zout, tick_zin, tick_prev, tick_next} = '0;
    endtask

    // Waits (bounded) for a command, accepts it, returns payload and committed values.
    task automatic run_cmd(output logic ok, output logic [1:0] code, output logic [1:0] cm,
                           output logic [1:0] cz, output logic [1:0] m, output logic [1:0] z);
        ok = 1'b0; code = '0; cm = '0; cz = '0; m = '0; z = '0;
        for (int i = 0; i < 20 && !cmd_valid; i++) step();
        if (cmd_valid) begin
            code = cmd_code; cm = cmd_mode; cz = cmd_zoom;
            cmd_ready = 1'b1;
            step();
            m = mode; z = zoom;
            proc_done = 1'b1;
            step();
            proc_done = 1'b0;
            ok = !busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {tick_next, tick_prev, tick_zin, tick_zout} = '0;
        {cmd_ready, proc_done, err_clr} = '0;
        #2;
        vectors++;
        if ({cmd_valid, cmd_code, cmd_mode, cmd_zoom, mode, zoom, busy, drop_err, timeout_err} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0", {cmd_valid, cmd_code, cmd_mode, cmd_zoom, mode, zoom, busy, drop_err, timeout_err});
        end
        vectors++;
        if (dut.pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pending: got %b want 0000", dut.pending);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cmd_ready = 1'b1;
        pulse(0);
        vectors++;
        if (cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_latency1: cmd_valid=%b want 0", cmd_valid);
        end
        step();
        vectors++;
        if ({cmd_valid, cmd_code, cmd_mode, cmd_zoom, busy} !== {1'b1, 2'd0, 2'd1, 2'd0, 1'b1}) begin
            miscompares++; $display("FAIL single_issue: got %b want 1000100 1", {cmd_valid, cmd_code, cmd_mode, cmd_zoom, busy});
        end
        step();
        vectors++;
        if ({cmd_valid, mode, busy} !== {1'b0, 2'd1, 1'b1}) begin
            miscompares++; $display("FAIL single_handshake: got %b want 0011", {cmd_valid, mode, busy});
        end
        step();
        step();
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        vectors++;
        if ({busy, mode} !== {1'b0, 2'd1}) begin
            miscompares++; $display("FAIL single_done: got %b want 001", {busy, mode});
        end
    endtask

    task automatic test_four();
        logic [1:0] exp_cm [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
        logic [1:0] exp_cz [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
        logic ok; logic [1:0] code, cm, cz, m, z;
        do_reset();
        cmd_ready = 1'b1;
        {tick_zout, tick_zin, tick_prev, tick_next} = 4'b1111;
        step();
        {tick_zout, tick_zin, tick_prev, tick_next} = '0;
        for (int k = 0; k < 4; k++) begin
            run_cmd(ok, code, cm, cz, m, z);
            vectors++;
            if ({ok, code, cm, cz, m, z} !== {1'b1, 2'(k), exp_cm[k], exp_cz[k], exp_cm[k], exp_cz[k]}) begin
                miscompares++;
                $display("FAIL four_cmd%0d: ok=%b code=%0d cm=%0d cz=%0d m=%0d z=%0d want code=%0d cm=%0d cz=%0d",
                         k, ok, code, cm, cz, m, z, k, exp_cm[k], exp_cz[k]);
            end
        end
        vectors++;
        if (drop_err !== 1'b0) begin
            miscompares++; $display("FAIL four_drop_err: got %b want 0", drop_err);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_m [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic ok; logic [1:0] code, cm, cz, m, z;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(0);
            run_cmd(ok, code, cm, cz, m, z);
            vectors++;
            if ({ok, m} !== {1'b1, exp_m[k]}) begin
                miscompares++; $display("FAIL wrap_next%0d: ok=%b mode=%0d want %0d", k, ok, m, exp_m[k]);
            end
        end
        pulse(1);
        run_cmd(ok, code, cm, cz, m, z);
        vectors++;
        if ({ok, code, m} !== {1'b1, 2'd1, 2'd3}) begin
            miscompares++; $display("FAIL wrap_prev: ok=%b code=%0d mode=%0d want code=1 mode=3", ok, code, m);
        end
    endtask

    task automatic test_saturate();
        logic ok; logic [1:0] code, cm, cz, m, z;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pulse(2);
            run_cmd(ok, code, cm, cz, m, z);
        end
        vectors++;
        if ({ok, z, m} !== {1'b1, 2'd3, 2'd0}) begin
            miscompares++; $display("FAIL sat_zoom_up: ok=%b zoom=%0d mode=%0d want zoom=3 mode=0", ok, z, m);
        end
        pulse(2);
        step();
        vectors++;
        if ({cmd_valid, busy, zoom, dut.rr_ptr, dut.pending} !== {1'b0, 1'b0, 2'd3, 2'd3, 4'b0000}) begin
            miscompares++;
            $display("FAIL sat_zin_noop: valid=%b busy=%b zoom=%0d rr=%0d pend=%b want 0 0 3 3 0000",
                     cmd_valid, busy, zoom, dut.rr_ptr, dut.pending);
        end
        for (int k = 0; k < 3; k++) begin
            pulse(3);
            run_cmd(ok, code, cm, cz, m, z);
        end
        vectors++;
        if ({ok, z} !== {1'b1, 2'd0}) begin
            miscompares++; $display("FAIL sat_zoom_down: ok=%b zoom=%0d want 0", ok, z);
        end
        pulse(3);
        step();
        step();
        vectors++;
        if ({cmd_valid, busy, zoom, dut.rr_ptr, dut.pending} !== {1'b0, 1'b0, 2'd0, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL sat_zout_noop: valid=%b busy=%b zoom=%0d rr=%0d pend=%b want 0 0 0 0 0000",
                     cmd_valid, busy, zoom, dut.rr_ptr, dut.pending);
        end
    endtask

    task automatic test_hold();
        logic ok; logic [1:0] code, cm, cz, m, z;
        do_reset();
        cmd_ready = 1'b0;
        pulse(0);
        step();
        for (int c = 0; c < 10; c++) begin
            if (c == 2 || c == 5) tick_next = 1'b1;
            step();
            tick_next = 1'b0;
            vectors++;
            if ({cmd_valid, cmd_code, cmd_mode, cmd_zoom} !== 7'b1_00_01_00) begin
                miscompares++;
                $display("FAIL hold_stable%0d: got %b want 1000100", c, {cmd_valid, cmd_code, cmd_mode, cmd_zoom});
            end
        end
        vectors++;
        if ({drop_err, dut.pending} !== {1'b1, 4'b0001}) begin
            miscompares++; $display("FAIL hold_drop: drop=%b pend=%b want 1 0001", drop_err, dut.pending);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++;
        if (drop_err !== 1'b0) begin
            miscompares++; $display("FAIL hold_err_clr: drop=%b want 0", drop_err);
        end
        run_cmd(ok, code, cm, cz, m, z);
        run_cmd(ok, code, cm, cz, m, z);
        vectors++;
        if ({ok, m} !== {1'b1, 2'd2}) begin
            miscompares++; $display("FAIL hold_second: ok=%b mode=%0d want 2", ok, m);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cmd_ready = 1'b1;
        pulse(0);
        step();
        step();
        vectors++;
        if ({cmd_valid, busy, mode} !== {1'b0, 1'b1, 2'd1}) begin
            miscompares++; $display("FAIL to_handshake: got %b want 0101", {cmd_valid, busy, mode});
        end
        for (int c = 0; c < 15; c++) step();
        vectors++;
        if ({busy, timeout_err} !== 2'b10) begin
            miscompares++; $display("FAIL to_early: busy=%b terr=%b want 1 0", busy, timeout_err);
        end
        step();
        vectors++;
        if ({busy, timeout_err, mode} !== {1'b0, 1'b1, 2'd1}) begin
            miscompares++; $display("FAIL to_expire: busy=%b terr=%b mode=%0d want 0 1 1", busy, timeout_err, mode);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL to_clr: terr=%b want 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_ready = 1'b0;
        pulse(0);
        step();
        pulse(2);
        vectors++;
        if ({cmd_valid, dut.pending} !== {1'b1, 4'b0100}) begin
            miscompares++; $display("FAIL rmid_pre: valid=%b pend=%b want 1 0100", cmd_valid, dut.pending);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_valid, busy, mode, dut.pending} !== {1'b0, 1'b0, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL rmid_async: valid=%b busy=%b mode=%0d pend=%b want 0 0 0 0000", cmd_valid, busy, mode, dut.pending);
        end
        rst = 1'b0;
        cmd_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        vectors++;
        if ({cmd_valid, busy} !== 2'b00) begin
            miscompares++; $display("FAIL rmid_quiet: valid=%b busy=%b want 0 0", cmd_valid, busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_four();
        test_wrap();
        test_saturate();
        test_hold();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
